// File: rtl/bodydrums_pkg.sv
// Shared types and widths for the drum-detection path (spectrum peak -> strike events).
package bodydrums_pkg;

    localparam int FREQ_W = 13;
    localparam int AMP_W  = 10;
    localparam int BAND_W = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ATTACK = 3'd1,
        FIRE   = 3'd2,
        HOLD   = 3'd3,
        REARM  = 3'd4
    } state_t;

endpackage

// File: rtl/freq_band_classifier.sv
// Combinational map from a peak frequency bin to one of four drum bands.
module freq_band_classifier
    import bodydrums_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F1 = 13'd100,
    parameter logic [FREQ_W-1:0] F2 = 13'd300,
    parameter logic [FREQ_W-1:0] F3 = 13'd700
) (
    input  logic [FREQ_W-1:0] max_freq,
    output logic [BAND_W-1:0] band
);

    always_comb begin
        if (max_freq < F1)      band = 2'd0;
        else if (max_freq < F2) band = 2'd1;
        else if (max_freq < F3) band = 2'd2;
        else                    band = 2'd3;
    end

endmodule

// File: rtl/drum_hit_detector.sv
// Turns one spectral peak per sweep into debounced drum strike events with
// frame-counted holdoff and amplitude hysteresis before re-arming.
module drum_hit_detector
    import bodydrums_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F1             = 13'd100,
    parameter logic [FREQ_W-1:0] F2             = 13'd300,
    parameter logic [FREQ_W-1:0] F3             = 13'd700,
    parameter logic [AMP_W-1:0]  AMP_ON         = 10'd200,
    parameter logic [AMP_W-1:0]  AMP_OFF        = 10'd120,
    parameter int unsigned       ON_FRAMES      = 2,
    parameter int unsigned       HOLDOFF_FRAMES = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // frame_valid is a bare strobe with no ready: max_freq/max_amp are consumed
    // in the cycle it is high and ignored in every other cycle.
    input  logic              frame_valid,
    input  logic [FREQ_W-1:0] max_freq,
    input  logic [AMP_W-1:0]  max_amp,
    output logic              hit,
    output logic [BAND_W-1:0] hit_band,
    output logic [AMP_W-1:0]  hit_velocity,
    output logic [7:0]        hit_count,
    output logic              armed,
    output state_t            fsm_state
);

    localparam logic [CNT_W-1:0] ON_CNT    = CNT_W'(ON_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF_FRAMES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0]   hold, hold_nxt;
    logic [AMP_W-1:0]   peak, peak_nxt;
    logic [BAND_W-1:0]  band_cap, band_nxt, band_in;
    logic               qualify;

    freq_band_classifier #(.F1(F1), .F2(F2), .F3(F3)) u_band (
        .max_freq (max_freq),
        .band     (band_in)
    );

    assign qualify = max_amp >= AMP_ON;
    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        peak_nxt  = peak;
        band_nxt  = band_cap;
        case (state)
            IDLE: begin
                if (frame_valid && qualify) begin
                    band_nxt  = band_in;
                    peak_nxt  = max_amp;
                    cnt_nxt   = 4'd1;
                    state_nxt = (ON_FRAMES == 1) ? FIRE : ATTACK;
                end
            end
            ATTACK: begin
                if (frame_valid) begin
                    if (!qualify) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (band_in != band_cap) begin
                        band_nxt = band_in;
                        peak_nxt = max_amp;
                        cnt_nxt  = 4'd1;
                    end else begin
                        cnt_nxt  = cnt_inc;
                        peak_nxt = (max_amp > peak) ? max_amp : peak;
                        if (cnt_inc == ON_CNT) state_nxt = FIRE;
                    end
                end
            end
            FIRE: begin
                // Any frame landing in this cycle is dropped on purpose.
                cnt_nxt   = '0;
                hold_nxt  = HOLD_INIT;
                state_nxt = (HOLDOFF_FRAMES == 0) ? REARM : HOLD;
            end
            HOLD: begin
                if (frame_valid) begin
                    hold_nxt = hold - 4'd1;
                    if (hold == 4'd1) state_nxt = REARM;
                end
            end
            REARM: begin
                if (frame_valid && (max_amp < AMP_OFF)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hold         <= '0;
            peak         <= '0;
            band_cap     <= '0;
            hit          <= 1'b0;
            hit_band     <= '0;
            hit_velocity <= '0;
            hit_count    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hold     <= hold_nxt;
            peak     <= peak_nxt;
            band_cap <= band_nxt;
            // Event fields are loaded on the edge entering FIRE so they are valid with hit.
            hit      <= (state_nxt == FIRE);
            if (state_nxt == FIRE) begin
                hit_band     <= band_nxt;
                hit_velocity <= peak_nxt;
                hit_count    <= hit_count + 8'd1;
            end
        end
    end

    assign armed     = (state == IDLE) || (state == ATTACK);
    assign fsm_state = state;

endmodule

// File: tb/tb_drum_hit_detector.sv
// Directed bench for drum_hit_detector: attack, band switch, holdoff, hysteresis,
// boundaries, reset abort and hit_count wrap, with a hit-event scoreboard.
module tb_drum_hit_detector;
  import bodydrums_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [12:0] max_freq = '0;
  logic [9:0]  max_amp = '0;
  logic        hit;
  logic [1:0]  hit_band;
  logic [9:0]  hit_velocity;
  logic [7:0]  hit_count;
  logic        armed;
  state_t      fsm_state;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  drum_hit_detector dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_valid  (frame_valid),
    .max_freq     (max_freq),
    .max_amp      (max_amp),
    .hit          (hit),
    .hit_band     (hit_band),
    .hit_velocity (hit_velocity),
    .hit_count    (hit_count),
    .armed        (armed),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    frame_valid = 1'b0;
    repeat (cycles) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // drivers: every task starts and ends on a falling edge
  task automatic send_frame(input logic [12:0] f, input logic [9:0] a, output logic got_hit);
    frame_valid = 1'b1;
    max_freq = f;
    max_amp = a;
    @(negedge clock);
    got_hit = hit;
    frame_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // from the FIRE cycle: leave FIRE, burn the 4 holdoff frames, re-arm
  task automatic rearm_full();
    logic g;
    idle(1);
    repeat (4) send_frame(13'd250, 10'd500, g);
    send_frame(13'd250, 10'd50, g);
  endtask

  // scoreboard: every hit pulse must match the next expected {band, velocity}
  always @(negedge clock) begin
    if (reset_n && hit) begin
      if (exp_q.size() == 0) check("unexpected_hit", 32'd1, 32'd0);
      else check("hit_event", {20'd0, hit_band, hit_velocity}, {20'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic g;
    logic [9:0] a2;
    @(negedge clock);
    do_reset(3);
    check("rst_hit", hit, 0);
    check("rst_armed", armed, 1);
    check("rst_count", hit_count, 0);
    check("rst_band", hit_band, 0);
    check("rst_vel", hit_velocity, 0);
    check("rst_state", fsm_state, IDLE);

    repeat (3) send_frame(13'd250, 10'd50, g);
    check("quiet_armed", armed, 1);
    check("quiet_count", hit_count, 0);

    // basic hit
    exp_q.push_back({2'd1, 10'd420});
    send_frame(13'd250, 10'd300, g);
    check("basic_no_early", g, 0);
    send_frame(13'd250, 10'd420, g);
    check("basic_latency", g, 1);
    check("basic_band", hit_band, 1);
    check("basic_vel", hit_velocity, 420);
    check("basic_count", hit_count, 1);
    check("basic_armed", armed, 0);
    idle(1);
    check("basic_one_cycle", hit, 0);
    idle(3);
    rearm_full();   // extra idle cycles already out of FIRE, harmless
    check("rearmed", armed, 1);

    // aborted attack
    send_frame(13'd50, 10'd300, g);
    check("abort_attack_state", fsm_state, ATTACK);
    send_frame(13'd50, 10'd150, g);
    check("abort_idle", fsm_state, IDLE);
    check("abort_nohit", g, 0);

    // band switch restarts attack
    exp_q.push_back({2'd3, 10'd310});
    send_frame(13'd50, 10'd300, g);
    send_frame(13'd800, 10'd300, g);
    check("switch_nohit", g, 0);
    send_frame(13'd800, 10'd310, g);
    check("switch_hit", g, 1);
    check("switch_band", hit_band, 3);
    check("switch_vel", hit_velocity, 310);
    check("switch_count", hit_count, 2);
    idle(1);

    // holdoff and hysteresis
    repeat (3) send_frame(13'd250, 10'd500, g);
    check("hold_still", fsm_state, HOLD);
    send_frame(13'd250, 10'd500, g);
    check("hold_done", fsm_state, REARM);
    send_frame(13'd250, 10'd150, g);
    check("rearm_150", fsm_state, REARM);
    send_frame(13'd250, 10'd100, g);
    check("rearm_100", fsm_state, IDLE);
    exp_q.push_back({2'd1, 10'd300});
    send_frame(13'd250, 10'd300, g);
    send_frame(13'd250, 10'd300, g);
    check("second_hit", g, 1);
    check("second_count", hit_count, 3);

    // frame in the FIRE cycle is ignored: holdoff still needs 4 frames
    send_frame(13'd250, 10'd500, g);
    repeat (3) send_frame(13'd250, 10'd500, g);
    check("fire_frame_ignored", fsm_state, HOLD);
    send_frame(13'd250, 10'd500, g);
    check("fire_hold_done", fsm_state, REARM);
    send_frame(13'd250, 10'd120, g);
    check("rearm_120", fsm_state, REARM);
    send_frame(13'd250, 10'd119, g);
    check("rearm_119", fsm_state, IDLE);

    // band boundaries
    exp_q.push_back({2'd0, 10'd250});
    send_frame(13'd99, 10'd250, g);
    send_frame(13'd99, 10'd250, g);
    check("band_99", hit_band, 0);
    rearm_full();
    exp_q.push_back({2'd1, 10'd250});
    send_frame(13'd100, 10'd250, g);
    send_frame(13'd100, 10'd250, g);
    check("band_100", hit_band, 1);
    rearm_full();
    exp_q.push_back({2'd2, 10'd250});
    send_frame(13'd699, 10'd250, g);
    send_frame(13'd699, 10'd250, g);
    check("band_699", hit_band, 2);
    rearm_full();
    exp_q.push_back({2'd3, 10'd250});
    send_frame(13'd700, 10'd250, g);
    send_frame(13'd700, 10'd250, g);
    check("band_700", hit_band, 3);
    rearm_full();

    // amplitude threshold
    send_frame(13'd250, 10'd199, g);
    send_frame(13'd250, 10'd199, g);
    check("amp_199", fsm_state, IDLE);
    exp_q.push_back({2'd1, 10'd200});
    send_frame(13'd250, 10'd200, g);
    send_frame(13'd250, 10'd200, g);
    check("amp_200", g, 1);
    check("amp_count", hit_count, 8);
    rearm_full();

    // reset mid-attack aborts
    send_frame(13'd250, 10'd300, g);
    check("mid_attack", fsm_state, ATTACK);
    do_reset(1);
    check("mid_rst_armed", armed, 1);
    check("mid_rst_state", fsm_state, IDLE);
    check("mid_rst_count", hit_count, 0);
    send_frame(13'd250, 10'd300, g);
    check("mid_rst_cnt_cleared", g, 0);
    do_reset(1);

    // 256 hits wrap hit_count
    for (int i = 0; i < 256; i++) begin
      a2 = 10'(200 + (i % 300));
      exp_q.push_back({2'd1, a2});
      send_frame(13'd250, 10'd200, g);
      send_frame(13'd250, a2, g);
      if (i == 0) check("wrap_first_vel", hit_velocity, 200);
      if (i == 254) check("wrap_255", hit_count, 255);
      rearm_full();
    end
    check("wrap_0", hit_count, 0);

    idle(2);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
